mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 153 +++++++++++++++
 tb/tb_mul_div_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit producing a 64-bit HI:LO result.
// Build macro MDU_SIGNED_EN adds signed MULT/DIV; without it every op is unsigned.
module mul_div_unit (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        busy,
   output logic        double_en,
   output logic [63:0] double_wdata
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic        is_div;
   logic [31:0] a_q, b_q;
   logic [31:0] hi, lo, m;

   logic [31:0] a_mag, b_mag;
   logic [32:0] sum;
   logic        ge;
   logic [31:0] diff;
   logic [31:0] hi_nx, lo_nx;
   logic [63:0] prod;
   logic [31:0] quo, rem;
   logic [63:0] result;

`ifdef MDU_SIGNED_EN
   logic is_signed;

   always_comb begin
      a_mag = (!op[0] && src_a[31]) ? -src_a : src_a;
      b_mag = (!op[0] && src_b[31]) ? -src_b : src_b;
   end
`else
   logic unused_op0;
   assign unused_op0 = op[0];

   always_comb begin
      a_mag = src_a;
      b_mag = src_b;
   end
`endif

   // One iteration: shift-add for multiply, restoring step for divide.
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
      ge   = ({hi, lo[31]} >= {1'b0, m});
      diff = {hi[30:0], lo[31]} - m;
      if (is_div) begin
         if (ge) begin
            hi_nx = diff;
            lo_nx = {lo[30:0], 1'b1};
         end else begin
            hi_nx = {hi[30:0], lo[31]};
            lo_nx = {lo[30:0], 1'b0};
         end
      end else begin
         hi_nx = sum[32:1];
         lo_nx = {sum[0], lo[31:1]};
      end
   end

   always_comb begin
      prod = {hi, lo};
      quo  = lo;
      rem  = hi;
`ifdef MDU_SIGNED_EN
      if (is_signed && (a_q[31] ^ b_q[31])) begin
         prod = -{hi, lo};
         quo  = -lo;
      end
      if (is_signed && a_q[31])
         rem = -hi;
`endif
      if (!is_div)
         result = prod;
      else if (b_q == '0)
         result = {a_q, {32{1'b1}}};
      else
         result = {rem, quo};
   end

   // CALC spends counts 0..31 iterating; count 32 applies the fix-up and latches the result.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state        <= IDLE;
         busy         <= 1'b0;
         double_en    <= 1'b0;
         double_wdata <= '0;
         cnt          <= '0;
         is_div       <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         hi           <= '0;
         lo           <= '0;
         m            <= '0;
`ifdef MDU_SIGNED_EN
         is_signed    <= 1'b0;
`endif
      end else if (flush) begin
         state     <= IDLE;
         busy      <= 1'b0;
         double_en <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= CALC;
                  busy   <= 1'b1;
                  cnt    <= '0;
                  is_div <= op[1];
                  a_q    <= src_a;
                  b_q    <= src_b;
                  hi     <= '0;
                  lo     <= op[1] ? a_mag : b_mag;
                  m      <= op[1] ? b_mag : a_mag;
`ifdef MDU_SIGNED_EN
                  is_signed <= !op[0];
`endif
               end
            end
            CALC: begin
               if (cnt == 6'd32) begin
                  state        <= DONE;
                  double_en    <= 1'b1;
                  double_wdata <= result;
               end else begin
                  hi  <= hi_nx;
                  lo  <= lo_nx;
                  cnt <= cnt + 6'd1;
               end
            end
            DONE: begin
               state     <= IDLE;
               busy      <= 1'b0;
               double_en <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               double_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases, control cases and random
// operations against an arithmetic reference model.
module tb_mul_div_unit;

   logic        clk;
   logic        rstn;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        busy;
   logic        double_en;
   logic [63:0] double_wdata;

   int unsigned n_vec;
   int unsigned n_err;
   logic [63:0] last_res;

   mul_div_unit dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .op           (op),
      .src_a        (src_a),
      .src_b        (src_b),
      .flush        (flush),
      .busy         (busy),
      .double_en    (double_en),
      .double_wdata (double_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic   sgn;
      longint sa, sb, q, r;
`ifdef MDU_SIGNED_EN
      sgn = !o[0];
`else
      sgn = 1'b0;
`endif
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!o[1]) begin
         if (sgn) return 64'(sa * sb);
         return {32'd0, a} * {32'd0, b};
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) begin
         q = sa / sb;
         r = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   // Full transaction: accept, 32 quiet cycles, one-cycle strobe on the 33rd, then idle.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input bit restart);
      bit early, moved;
      early = 1'b0;
      moved = 1'b0;
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      for (int k = 1; k <= 32; k++) begin
         if (restart && k == 5) begin
            start = 1'b1; op = ~o; src_a = ~a; src_b = b + 32'd1;
         end
         @(negedge clk);
         start = 1'b0;
         if (double_en) early = 1'b1;
         if (double_wdata !== last_res) moved = 1'b1;
      end
      check({tag, "_early_en"}, {63'd0, early}, 64'd0);
      check({tag, "_hold"}, {63'd0, moved}, 64'd0);
      @(negedge clk);
      check({tag, "_en"}, {63'd0, double_en}, 64'd1);
      check({tag, "_data"}, double_wdata, exp);
      last_res = exp;
      @(negedge clk);
      check({tag, "_en_drop"}, {63'd0, double_en}, 64'd0);
      check({tag, "_idle"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic watch_quiet(input string tag, input int unsigned cycles);
      bit seen;
      seen = 1'b0;
      for (int unsigned k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (double_en) seen = 1'b1;
      end
      check({tag, "_no_en"}, {63'd0, seen}, 64'd0);
      check({tag, "_data_kept"}, double_wdata, last_res);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      n_vec = 0; n_err = 0; last_res = '0;
      rstn = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_en", {63'd0, double_en}, 64'd0);
      check("rst_data", double_wdata, 64'd0);
      rstn = 1'b1;

      run_op("multu_ff", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 1'b0);
      run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
      run_op("divu_by0", 2'b11, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1'b0);
`ifdef MDU_SIGNED_EN
      run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
      run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
      run_op("div_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF, 1'b0);
`else
      run_op("mult_uns", 2'b00, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB, 1'b0);
      run_op("div_uns", 2'b10, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC, 1'b0);
      run_op("div_big", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
`endif

      // start pulsed mid-CALC must not disturb the operation in flight
      run_op("restart", 2'b01, 32'd12345, 32'd678, 64'd8369910, 1'b1);

      // flush at CALC cycle 10
      @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'hDEAD_BEEF; src_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {63'd0, busy}, 64'd0);
      watch_quiet("flush", 40);

      // start and flush together in IDLE
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 2'b11; src_a = 32'd50; src_b = 32'd5;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("sf_busy", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      check("sf_busy_late", {63'd0, busy}, 64'd0);
      watch_quiet("sf", 36);

      // flush while the strobe is high
      @(negedge clk);
      start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (33) @(negedge clk);
      check("fdone_en", {63'd0, double_en}, 64'd1);
      last_res = {32'd1, 32'd111};
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("fdone_en_drop", {63'd0, double_en}, 64'd0);
      check("fdone_data", double_wdata, last_res);
      check("fdone_busy", {63'd0, busy}, 64'd0);

      // reset mid-CALC
      @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'd77; src_b = 32'd99;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      last_res = '0;
      check("rcalc_busy", {63'd0, busy}, 64'd0);
      check("rcalc_data", double_wdata, 64'd0);
      watch_quiet("rcalc", 40);

      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
